imm_ext_pipe: RTL and testbench

Registered, parametrised immediate generator for the RISC-V pipelined core. It sits on the Decode→Execute boundary, taking the raw Decode-stage instruction word and immediate-format select. It produces the sign- or zero-extended immediate after a configurable number of register stages. It obeys the hazard unit's stall and flush controls, adds U-type, CSR-zimm and shift-amount formats, and flags illegal format selects.

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_decode.sv | 51 +++++
 rtl/imm_ext_pipe.sv | 94 +++++++++
 tb/tb_imm_ext_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the Decode->Execute immediate generator.
//   immsrc_t     : 3-bit immediate format select as driven by the decoder.
//   XLEN_*       : legal datapath widths.
//   STAGES_*     : legal range of pipeline register stages.
//   params_legal : elaboration-time parameter legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } immsrc_t;

  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;
  localparam int STAGES_MIN  = 1;
  localparam int STAGES_MAX  = 3;

  function automatic logic params_legal(input int xlen, input int stages);
    return ((xlen == XLEN_NARROW) || (xlen == XLEN_WIDE)) &&
           (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode -- combinational immediate extraction for all RV formats.
//   instr  in  32    raw instruction word
//   immsrc in  3     format select (imm_pkg::immsrc_t encoding)
//   imm    out XLEN  sign/zero-extended immediate (0 for the reserved select)
//   bad    out 1     immsrc was the reserved encoding
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic            bad
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode_s;
  assign unused_opcode_s = ^instr[6:0];

  // Format mux; signed size casts replicate instr[31] up to XLEN.
  always_comb begin
    imm = '0;
    bad = 1'b0;
    case (immsrc_t'(immsrc))
      IMM_I:   imm = XLEN'($signed(instr[31:20]));
      IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:   imm = XLEN'($signed({instr[31:12], 12'h000}));
      IMM_Z:   imm = XLEN'(instr[19:15]);
      IMM_SH: begin
        // RV64 shift amounts are 6 bits wide, RV32 only 5.
        if (XLEN == XLEN_WIDE) begin
          imm = XLEN'(instr[25:20]);
        end else begin
          imm = XLEN'(instr[24:20]);
        end
      end
      IMM_RSV: begin
        imm = '0;
        bad = 1'b1;
      end
      default: begin
        imm = '0;
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe -- registered immediate generator on the Decode->Execute boundary.
//   clk        in  1     core clock
//   reset      in  1     asynchronous active-high reset
//   instr_d    in  32    Decode-stage instruction word
//   immsrc_d   in  3     immediate format select
//   valid_d    in  1     live instruction on instr_d/immsrc_d
//   stall_e    in  1     hold all stages
//   flush_e    in  1     clear all stages (wins over stall_e)
//   immext_e   out XLEN  extended immediate, STAGES edges after capture
//   valid_e    out 1     immext_e belongs to a live instruction
//   bad_src_e  out 1     captured select was the reserved encoding
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [2:0]      immsrc_d,
  input  logic            valid_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic [XLEN-1:0] immext_e,
  output logic            valid_e,
  output logic            bad_src_e
);

  if (!params_legal(XLEN, STAGES)) begin : g_param_check
    $fatal(1, "imm_ext_pipe: illegal parameters XLEN=%0d STAGES=%0d", XLEN, STAGES);
  end

  logic [XLEN-1:0] gen_imm_s;
  logic            gen_bad_s;
  logic            live_bad_s;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (instr_d),
    .immsrc (immsrc_d),
    .imm    (gen_imm_s),
    .bad    (gen_bad_s)
  );

  // A bubble never reports a bad select, even though its immediate is kept.
  assign live_bad_s = gen_bad_s & valid_d;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [XLEN-1:0] d_imm_s;
    logic            d_valid_s;
    logic            d_bad_s;
    logic [XLEN-1:0] imm_r;
    logic            valid_r;
    logic            bad_r;

    if (g == 0) begin : g_head
      assign d_imm_s   = gen_imm_s;
      assign d_valid_s = valid_d;
      assign d_bad_s   = live_bad_s;
    end else begin : g_link
      assign d_imm_s   = g_stage[g-1].imm_r;
      assign d_valid_s = g_stage[g-1].valid_r;
      assign d_bad_s   = g_stage[g-1].bad_r;
    end

    // Stage register: flush clears, stall holds, otherwise advance one stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        imm_r   <= '0;
        valid_r <= 1'b0;
        bad_r   <= 1'b0;
      end else if (flush_e) begin
        imm_r   <= '0;
        valid_r <= 1'b0;
        bad_r   <= 1'b0;
      end else if (!stall_e) begin
        imm_r   <= d_imm_s;
        valid_r <= d_valid_s;
        bad_r   <= d_bad_s;
      end else begin
        imm_r   <= imm_r;
        valid_r <= valid_r;
        bad_r   <= bad_r;
      end
    end
  end

  assign immext_e  = g_stage[STAGES-1].imm_r;
  assign valid_e   = g_stage[STAGES-1].valid_r;
  assign bad_src_e = g_stage[STAGES-1].bad_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe -- three configurations (32/1, 32/2, 64/3) share one input
// stream; each is checked against a queue-based reference of the pipeline.
module tb_imm_ext_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        v;
    logic        b;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'd0;
  logic [2:0]  immsrc_d = 3'd0;
  logic        valid_d = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;

  logic [31:0] imm_a, imm_b;
  logic [63:0] imm_c;
  logic        v_a, v_b, v_c, b_a, b_b, b_c;

  int total = 0;
  int bad = 0;

  ent_t        mq[3][$];
  int          depth[3] = '{1, 2, 3};
  int          xl[3]    = '{32, 32, 64};
  logic [65:0] obs[3];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .reset(reset), .instr_d(instr_d), .immsrc_d(immsrc_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .immext_e(imm_a), .valid_e(v_a), .bad_src_e(b_a));
  imm_ext_pipe #(.XLEN(32), .STAGES(2)) u_b (
    .clk(clk), .reset(reset), .instr_d(instr_d), .immsrc_d(immsrc_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .immext_e(imm_b), .valid_e(v_b), .bad_src_e(b_b));
  imm_ext_pipe #(.XLEN(64), .STAGES(3)) u_c (
    .clk(clk), .reset(reset), .instr_d(instr_d), .immsrc_d(immsrc_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .immext_e(imm_c), .valid_e(v_c), .bad_src_e(b_c));

  assign obs[0] = {32'd0, imm_a, v_a, b_a};
  assign obs[1] = {32'd0, imm_b, v_b, b_b};
  assign obs[2] = {imm_c, v_c, b_c};

  // Immediate value as a number: unsigned field weights, minus the sign weight.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint r;
    longint s;
    s = ins[31] ? 64'sd1 : 64'sd0;
    case (src)
      3'd0: r = longint'(ins[31:20]) - s * 64'sd4096;
      3'd1: r = longint'(ins[31:25]) * 64'sd32 + longint'(ins[11:7]) - s * 64'sd4096;
      3'd2: r = longint'(ins[7]) * 64'sd2048 + longint'(ins[30:25]) * 64'sd32
                + longint'(ins[11:8]) * 64'sd2 - s * 64'sd4096;
      3'd3: r = longint'(ins[19:12]) * 64'sd4096 + longint'(ins[20]) * 64'sd2048
                + longint'(ins[30:21]) * 64'sd2 - s * 64'sd1048576;
      3'd4: r = longint'(ins[31:12]) * 64'sd4096 - s * 64'sd4294967296;
      3'd5: r = longint'(ins[19:15]);
      3'd6: r = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: r = 64'sd0;
    endcase
    if (xlen == 32) r = r & 64'sh0000_0000_FFFF_FFFF;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      for (int s = 0; s < depth[i]; s++) mq[i].push_back(66'd0);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      if (flush_e) begin
        for (int s = 0; s < depth[i]; s++) mq[i][s] = 66'd0;
      end else if (!stall_e) begin
        e.imm = ref_imm(instr_d, immsrc_d, xl[i]);
        e.v   = valid_d;
        e.b   = valid_d && (immsrc_d == 3'b111);
        mq[i].push_front(e);
        void'(mq[i].pop_back());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic v);
    instr_d  = ins;
    immsrc_d = src;
    valid_d  = v;
  endtask

  task automatic test_reset();
    ent_t e;
    model_clear();
    #12;
    for (int i = 0; i < 3; i++) begin
      e = mq[i][mq[i].size()-1];
      total++;
      if (obs[i] !== e || obs[i] !== 66'd0) begin
        bad++;
        $display("FAIL reset dut%0d: got %h want %h", i, obs[i], e);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_i_type();
    drive(32'hFFF0_0093, 3'b000, 1'b1);
    tick();
    total++;
    if ({imm_a, v_a, b_a} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL i_type: got imm=%h v=%b b=%b want imm=ffffffff v=1 b=0", imm_a, v_a, b_a);
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    drive(32'hFE11_2E23, 3'b001, 1'b1);
    tick();
    total++;
    if (imm_a !== 32'hFFFF_FFFC || v_a !== 1'b1) begin
      bad++;
      $display("FAIL b2b_s: got imm=%h v=%b want imm=fffffffc v=1", imm_a, v_a);
    end
    drive(32'h1234_50B7, 3'b100, 1'b1);
    tick();
    total++;
    if (imm_a !== 32'h1234_5000 || imm_b !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL b2b_u: got a=%h b=%h want a=12345000 b=fffffffc", imm_a, imm_b);
    end
    for (int i = 0; i < 3; i++) begin
      e = mq[i][mq[i].size()-1];
      total++;
      if (obs[i] !== e) begin
        bad++;
        $display("FAIL b2b_model dut%0d: got %h want %h", i, obs[i], e);
      end
    end
  endtask

  task automatic test_j_latency64();
    ent_t e;
    drive(32'hFFDF_F06F, 3'b011, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      drive($urandom, 3'($urandom_range(0, 7)), 1'b0);
      e = mq[2][mq[2].size()-1];
      total++;
      if (obs[2] !== e) begin
        bad++;
        $display("FAIL j64_edge%0d: got %h want %h", k, obs[2], e);
      end
    end
    total++;
    if (imm_c !== 64'hFFFF_FFFF_FFFF_FFFC || v_c !== 1'b1) begin
      bad++;
      $display("FAIL j64_final: got imm=%h v=%b want imm=fffffffffffffffc v=1", imm_c, v_c);
    end
  endtask

  task automatic test_stall_flush();
    drive(32'hFFF0_0093, 3'b000, 1'b1);
    tick();
    stall_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive($urandom, 3'($urandom_range(0, 6)), 1'b1);
      tick();
      total++;
      if (imm_a !== 32'hFFFF_FFFF || v_a !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d: got imm=%h v=%b want imm=ffffffff v=1", k, imm_a, v_a);
      end
    end
    flush_e = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== 66'd0) begin
        bad++;
        $display("FAIL stall_flush dut%0d: got %h want 0", i, obs[i]);
      end
    end
    stall_e = 1'b0;
    flush_e = 1'b0;
  endtask

  task automatic test_reserved_zext();
    ent_t e;
    drive(32'hABCD_E123, 3'b111, 1'b1);
    tick();
    total++;
    if (imm_a !== 32'd0 || b_a !== 1'b1 || v_a !== 1'b1) begin
      bad++;
      $display("FAIL reserved: got imm=%h b=%b v=%b want imm=0 b=1 v=1", imm_a, b_a, v_a);
    end
    drive(32'h000F_8073, 3'b101, 1'b1);
    tick();
    total++;
    if (imm_a !== 32'h0000_001F || b_a !== 1'b0) begin
      bad++;
      $display("FAIL zimm: got imm=%h b=%b want imm=0000001f b=0", imm_a, b_a);
    end
    drive(32'h41F0_D093, 3'b110, 1'b1);
    tick();
    total++;
    if (imm_a !== 32'h0000_001F) begin
      bad++;
      $display("FAIL shamt32: got %h want 0000001f", imm_a);
    end
    drive(32'hFFFF_FFFF, 3'b111, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      e = mq[i][mq[i].size()-1];
      total++;
      if (obs[i] !== e) begin
        bad++;
        $display("FAIL fmt_model dut%0d: got %h want %h", i, obs[i], e);
      end
    end
  endtask

  task automatic test_random();
    ent_t e;
    for (int n = 0; n < 400; n++) begin
      drive($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      stall_e = ($urandom_range(0, 4) == 0);
      flush_e = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        e = mq[i][mq[i].size()-1];
        total++;
        if (obs[i] !== e) begin
          bad++;
          $display("FAIL random%0d dut%0d: got %h want %h", n, i, obs[i], e);
        end
      end
    end
    stall_e = 1'b0;
    flush_e = 1'b0;
  endtask

  task automatic test_async_reset();
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      drive($urandom | 32'h8000_0000, 3'b000, 1'b1);
      tick();
    end
    #3;
    stall_e = 1'b1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== 66'd0) begin
        bad++;
        $display("FAIL async_reset dut%0d: got %h want 0", i, obs[i]);
      end
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    stall_e = 1'b0;
    drive($urandom, 3'($urandom_range(0, 7)), 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      e = mq[i][mq[i].size()-1];
      total++;
      if (obs[i] !== e) begin
        bad++;
        $display("FAIL post_reset dut%0d: got %h want %h", i, obs[i], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_back_to_back();
    test_j_latency64();
    test_stall_flush();
    test_reserved_zext();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
